// File: rtl/gba_cart_bridge.sv
// GBA cartridge bridge: routes CPU bus requests to a word-wide ROM store (with a
// one-entry line buffer) or a byte-wide backup SRAM, stalling the CPU as needed.
module gba_cart_bridge #(
    parameter int ROM_AW  = 25,
    parameter int SRAM_AW = 15,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [31:0]        cart_addr,
    input  logic               cart_rd,
    input  logic               cart_wr,
    input  logic [31:0]        cart_wdata,
    output logic [31:0]        cart_rdata,
    output logic               cart_pause,
    output logic [ROM_AW-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we,
    output logic [7:0]         sram_wdata,
    input  logic [7:0]         sram_rdata,
    input  logic               flush,
    input  logic               err_clr,
    output logic               err
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ROM_WAIT, SRAM_RD, SRAM_CAP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_buf_valid;
    logic [ROM_AW-3:0]  r_buf_tag;
    logic [31:0]        r_buf_data;
    logic [31:0]        r_rdata;
    logic               r_pause;
    logic [ROM_AW-1:0]  r_mem_addr;
    logic               r_mem_rd;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic               r_sram_we;
    logic [7:0]         r_sram_wdata;
    logic               r_err;

    logic        w_idle, w_req, w_is_sram, w_rd_acc, w_wr_acc, w_hit;
    logic        w_rom_miss, w_sram_rd, w_sram_wr, w_ack, w_timeout, w_err_set;
    logic [31:0] w_rdata_nxt;
    logic        w_unused;

    assign w_idle     = (r_state == IDLE);
    assign w_req      = cart_rd | cart_wr;
    assign w_is_sram  = (cart_addr[27:24] == 4'hE) || (cart_addr[27:24] == 4'hF);
    // A simultaneous rd+wr is handled as a write.
    assign w_wr_acc   = w_idle & cart_wr;
    assign w_rd_acc   = w_idle & cart_rd & ~cart_wr;
    assign w_hit      = r_buf_valid && (r_buf_tag == cart_addr[ROM_AW-1:2]);
    assign w_rom_miss = w_rd_acc & ~w_is_sram & ~w_hit;
    assign w_sram_rd  = w_rd_acc & w_is_sram;
    assign w_sram_wr  = w_wr_acc & w_is_sram;
    assign w_ack      = (r_state == ROM_WAIT) & mem_ack;
    assign w_timeout  = (r_state == ROM_WAIT) & ~mem_ack & (r_cnt == CNT_LAST);
    assign w_err_set  = (w_req & ~w_idle) | (cart_rd & cart_wr) | w_timeout;
    assign w_unused   = &{1'b0, cart_addr[31:28]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_rom_miss)     w_next_state = ROM_WAIT;
                else if (w_sram_rd) w_next_state = SRAM_RD;
            end
            ROM_WAIT: if (w_ack || w_timeout) w_next_state = IDLE;
            SRAM_RD:  w_next_state = SRAM_CAP;
            SRAM_CAP: w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_rdata_nxt = r_rdata;
        if (w_rd_acc && !w_is_sram && w_hit) w_rdata_nxt = r_buf_data;
        else if (w_ack)                      w_rdata_nxt = mem_rdata;
        else if (w_timeout)                  w_rdata_nxt = 32'hFFFF_FFFF;
        else if (r_state == SRAM_CAP)        w_rdata_nxt = {4{sram_rdata}};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rdata      <= '0;
            r_pause      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_we    <= 1'b0;
            r_sram_wdata <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_buf_valid  <= 1'b0;
        end else begin
            r_rdata   <= w_rdata_nxt;
            r_pause   <= (w_next_state != IDLE);
            r_sram_we <= w_sram_wr;

            if (w_rom_miss) begin
                r_mem_addr <= {cart_addr[ROM_AW-1:2], 2'b00};
                r_mem_rd   <= 1'b1;
            end else if (w_ack || w_timeout) begin
                r_mem_rd   <= 1'b0;
            end

            if (w_sram_rd || w_sram_wr) r_sram_addr  <= cart_addr[SRAM_AW-1:0];
            if (w_sram_wr)              r_sram_wdata <= cart_wdata[{cart_addr[1:0], 3'b000} +: 8];

            // Held at zero outside ROM_WAIT, so every wait starts from a cleared count.
            if (r_state != ROM_WAIT)  r_cnt <= '0;
            else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);

            if (w_err_set)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;

            if (flush)      r_buf_valid <= 1'b0;
            else if (w_ack) r_buf_valid <= 1'b1;
        end
    end

    // NOTE: tag and data are left unreset; they are only consulted while r_buf_valid is set.
    always_ff @(posedge clk) begin
        if (w_ack) begin
            r_buf_tag  <= r_mem_addr[ROM_AW-1:2];
            r_buf_data <= mem_rdata;
        end
    end

    assign cart_rdata = r_rdata;
    assign cart_pause = r_pause;
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign sram_addr  = r_sram_addr;
    assign sram_we    = r_sram_we;
    assign sram_wdata = r_sram_wdata;
    assign err        = r_err;
endmodule

// File: tb/tb_gba_cart_bridge.sv
// Bench for gba_cart_bridge: directed transactions drive a transaction-level
// model whose expectations are compared against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_gba_cart_bridge;
    localparam int ROM_AW  = 25;
    localparam int SRAM_AW = 15;
    localparam int TIMEOUT = 255;

    logic               clk;
    logic               rst_b;
    logic [31:0]        cart_addr, cart_wdata, cart_rdata, mem_rdata;
    logic               cart_rd, cart_wr, cart_pause, mem_rd, mem_ack;
    logic [ROM_AW-1:0]  mem_addr;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_we, flush, err_clr, err;
    logic [7:0]         sram_wdata, sram_rdata;

    gba_cart_bridge #(.ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b),
        .cart_addr(cart_addr), .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_wdata(cart_wdata),
        .cart_rdata(cart_rdata), .cart_pause(cart_pause),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .flush(flush), .err_clr(err_clr), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM device: read data appears one cycle after the address.
    logic [7:0] sram_dev [0:(1<<SRAM_AW)-1];
    always @(posedge clk) begin
        if (sram_we) sram_dev[sram_addr] <= sram_wdata;
        sram_rdata <= sram_dev[sram_addr];
    end

    // Transaction model state and the per-cycle expectations it produces.
    bit                 m_valid;
    logic [ROM_AW-3:0]  m_tag;
    logic [31:0]        m_data;
    bit                 m_err;
    logic [7:0]         m_sram [0:(1<<SRAM_AW)-1];

    logic [31:0]        exp_rdata;
    logic               exp_pause, exp_mem_rd, exp_sram_we;
    logic [ROM_AW-1:0]  exp_mem_addr;
    logic [SRAM_AW-1:0] exp_sram_addr;
    logic [7:0]         exp_sram_wdata;
    bit                 check_en;

    int n_checks, n_fail;
    int tot_pause, tot_memrd, tot_we;
    logic [ROM_AW-1:0] last_mem_addr;
    logic [7:0]        last_sram_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        tot_pause += int'(cart_pause);
        tot_memrd += int'(mem_rd);
        tot_we    += int'(sram_we);
        if (mem_rd)  last_mem_addr   = mem_addr;
        if (sram_we) last_sram_wdata = sram_wdata;
        if (check_en) begin
            check("cyc_pause",   32'(cart_pause), 32'(exp_pause));
            check("cyc_mem_rd",  32'(mem_rd),     32'(exp_mem_rd));
            check("cyc_rdata",   cart_rdata,      exp_rdata);
            check("cyc_err",     32'(err),        32'(m_err));
            check("cyc_sram_we", 32'(sram_we),    32'(exp_sram_we));
            if (exp_mem_rd)  check("cyc_mem_addr",   32'(mem_addr),   32'(exp_mem_addr));
            if (exp_sram_we) check("cyc_sram_addr",  32'(sram_addr),  32'(exp_sram_addr));
            if (exp_sram_we) check("cyc_sram_wdata", 32'(sram_wdata), 32'(exp_sram_wdata));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ack_at = cycle of the wait in which mem_ack is given (0 = never);
    // poke_at = wait cycle in which a stray read is issued (0 = none).
    task automatic rom_read(input logic [31:0] addr, input int ack_at, input logic [31:0] data,
                            input bit flush_at_ack, input int poke_at);
        bit hit;
        int limit;
        hit = m_valid && (m_tag == addr[ROM_AW-1:2]);
        cart_addr = addr;
        cart_rd   = 1'b1;
        step();
        cart_rd = 1'b0;
        if (hit) begin
            exp_rdata = m_data;
            return;
        end
        exp_pause    = 1'b1;
        exp_mem_rd   = 1'b1;
        exp_mem_addr = {addr[ROM_AW-1:2], 2'b00};
        limit = (ack_at > 0) ? ack_at : TIMEOUT;
        for (int k = 1; k <= limit; k++) begin
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
                flush     = flush_at_ack;
            end
            if (k == poke_at) begin
                cart_rd   = 1'b1;
                cart_addr = 32'h0800_0F00;
            end
            step();
            mem_ack = 1'b0;
            flush   = 1'b0;
            cart_rd = 1'b0;
            if (k == poke_at) m_err = 1'b1;
        end
        exp_pause  = 1'b0;
        exp_mem_rd = 1'b0;
        if (ack_at > 0) begin
            exp_rdata = data;
            m_valid   = !flush_at_ack;
            m_tag     = addr[ROM_AW-1:2];
            m_data    = data;
        end else begin
            exp_rdata = 32'hFFFF_FFFF;
            m_err     = 1'b1;
        end
    endtask

    task automatic sram_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] sh;
        sh = wdata >> (8 * int'(addr[1:0]));
        cart_addr  = addr;
        cart_wdata = wdata;
        cart_wr    = 1'b1;
        step();
        cart_wr        = 1'b0;
        exp_sram_we    = 1'b1;
        exp_sram_addr  = addr[SRAM_AW-1:0];
        exp_sram_wdata = sh[7:0];
        m_sram[addr[SRAM_AW-1:0]] = sh[7:0];
        step();
        exp_sram_we = 1'b0;
    endtask

    task automatic sram_read(input logic [31:0] addr);
        cart_addr = addr;
        cart_rd   = 1'b1;
        step();
        cart_rd   = 1'b0;
        exp_pause = 1'b1;
        step();
        step();
        exp_pause = 1'b0;
        exp_rdata = {4{m_sram[addr[SRAM_AW-1:0]]}};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"},      cart_rdata,       32'h0);
        check({tag, "_pause"},      32'(cart_pause),  32'h0);
        check({tag, "_mem_addr"},   32'(mem_addr),    32'h0);
        check({tag, "_mem_rd"},     32'(mem_rd),      32'h0);
        check({tag, "_sram_addr"},  32'(sram_addr),   32'h0);
        check({tag, "_sram_we"},    32'(sram_we),     32'h0);
        check({tag, "_sram_wdata"}, 32'(sram_wdata),  32'h0);
        check({tag, "_err"},        32'(err),         32'h0);
    endtask

    int b_pause, b_memrd, b_we;

    initial begin
        rst_b = 1'b1;
        cart_addr = '0; cart_rd = 1'b0; cart_wr = 1'b0; cart_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0; err_clr = 1'b0;
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_err = 1'b0;
        exp_rdata = '0; exp_pause = 1'b0; exp_mem_rd = 1'b0; exp_mem_addr = '0;
        exp_sram_we = 1'b0; exp_sram_addr = '0; exp_sram_wdata = '0;
        check_en = 1'b0;
        for (int i = 0; i < (1 << SRAM_AW); i++) begin
            sram_dev[i] = 8'h00;
            m_sram[i]   = 8'h00;
        end
        #1 rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_b = 1'b1;
        step();
        check_en = 1'b1;

        // ROM miss, ack in the 5th wait cycle
        b_pause = tot_pause; b_memrd = tot_memrd;
        rom_read(32'h0800_0104, 5, 32'h1234_5678, 1'b0, 0);
        check("miss_rdata",        cart_rdata,             32'h1234_5678);
        check("miss_mem_addr",     32'(last_mem_addr),     32'h104);
        check("miss_pause_cycles", tot_pause - b_pause,    32'd5);
        check("miss_memrd_cycles", tot_memrd - b_memrd,    32'd5);
        step();

        // SRAM write to byte lane 3, then read it back
        b_we = tot_we;
        sram_write(32'h0E00_0003, 32'hAB00_0000);
        check("sram_we_cycles", tot_we - b_we,         32'd1);
        check("sram_wdata",     32'(last_sram_wdata),  32'hAB);
        b_pause = tot_pause;
        sram_read(32'h0E00_0003);
        check("sram_rdata",        cart_rdata,          32'hABAB_ABAB);
        check("sram_pause_cycles", tot_pause - b_pause, 32'd2);
        step();

        // Buffer hit on another byte of the same word
        b_pause = tot_pause; b_memrd = tot_memrd;
        rom_read(32'h0800_0106, 3, 32'hDEAD_DEAD, 1'b0, 0);
        check("hit_rdata", cart_rdata, 32'h1234_5678);
        step();
        check("hit_pause_cycles", tot_pause - b_pause, 32'd0);
        check("hit_memrd_cycles", tot_memrd - b_memrd, 32'd0);

        // ROM write is ignored entirely
        b_pause = tot_pause; b_memrd = tot_memrd;
        cart_addr = 32'h0800_0104; cart_wdata = 32'h5555_AAAA; cart_wr = 1'b1;
        step();
        cart_wr = 1'b0;
        step();
        check("romwr_pause_cycles", tot_pause - b_pause, 32'd0);
        check("romwr_memrd_cycles", tot_memrd - b_memrd, 32'd0);

        // Timeout: no ack ever arrives
        b_pause = tot_pause;
        rom_read(32'h0800_0200, 0, 32'h0, 1'b0, 0);
        check("to_rdata",        cart_rdata,          32'hFFFF_FFFF);
        check("to_err",          32'(err),            32'h1);
        check("to_mem_rd",       32'(mem_rd),         32'h0);
        check("to_pause_cycles", tot_pause - b_pause, 32'd255);
        rom_read(32'h0800_0104, 5, 32'h0, 1'b0, 0);
        check("to_buf_kept", cart_rdata, 32'h1234_5678);

        // err_clr, then err_clr colliding with a rd+wr error (set wins)
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", 32'(err), 32'h0);
        cart_addr = 32'h0800_0000; cart_rd = 1'b1; cart_wr = 1'b1; err_clr = 1'b1;
        step();
        cart_rd = 1'b0; cart_wr = 1'b0; err_clr = 1'b0;
        m_err = 1'b1;
        check("err_set_wins", 32'(err), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 1'b0;

        // Flush on the ack cycle: the same word misses again
        rom_read(32'h0800_0300, 3, 32'hCAFE_F00D, 1'b1, 0);
        b_memrd = tot_memrd;
        rom_read(32'h0800_0300, 2, 32'hCAFE_F00D, 1'b0, 0);
        check("flush_remiss_memrd", tot_memrd - b_memrd, 32'd2);
        check("flush_remiss_rdata", cart_rdata,          32'hCAFE_F00D);

        // Standalone flush, then an ack on the very first wait cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_valid = 1'b0;
        b_memrd = tot_memrd;
        rom_read(32'h0800_0300, 1, 32'h0102_0304, 1'b0, 0);
        check("flush_ack1_memrd", tot_memrd - b_memrd, 32'd1);

        // Stray read during ROM_WAIT is dropped and flagged
        rom_read(32'h0800_0400, 4, 32'h0BAD_BEEF, 1'b0, 2);
        check("poke_err",   32'(err), 32'h1);
        check("poke_rdata", cart_rdata, 32'h0BAD_BEEF);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 1'b0;

        // Reset in the middle of ROM_WAIT, then a late ack
        cart_addr = 32'h0800_0500; cart_rd = 1'b1;
        step();
        cart_rd = 1'b0;
        exp_pause = 1'b1; exp_mem_rd = 1'b1; exp_mem_addr = 25'h500;
        step();
        step();
        #1 rst_b = 1'b0;
        #1;
        check_all_zero("midrst");
        m_valid = 1'b0; m_err = 1'b0;
        exp_rdata = '0; exp_pause = 1'b0; exp_mem_rd = 1'b0; exp_sram_we = 1'b0;
        step();
        rst_b = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        check("late_ack_mem_rd", 32'(mem_rd),  32'h0);
        check("late_ack_rdata",  cart_rdata,   32'h0);
        step();

        // Buffer was invalidated by reset: this read must miss
        b_memrd = tot_memrd;
        rom_read(32'h0800_0104, 2, 32'h1234_5678, 1'b0, 0);
        check("post_rst_miss_memrd", tot_memrd - b_memrd, 32'd2);
        step();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
